// File: rtl/watch_calendar.sv
// Second-resolution calendar counter with validated time-set, 12-hour view,
// rollover strobes and a minute-resolution alarm. Weekday is tracked incrementally.
module watch_calendar #(
  parameter int YEAR_W    = 12,
  parameter int YEAR_MIN  = 1,
  parameter int YEAR_MAX  = 4095,
  parameter int RST_YEAR  = 2021,
  parameter int RST_MONTH = 6,
  parameter int RST_DAY   = 2,
  parameter int RST_HOUR  = 6,
  parameter int RST_WEEK  = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clk1sec,
  input  logic              i_set_time,
  input  logic [YEAR_W+39:0] i_bin_time,
  input  logic [2:0]        i_set_week,
  input  logic              i_alarm_en,
  input  logic [7:0]        i_alarm_hour,
  input  logic [7:0]        i_alarm_min,
  output logic [YEAR_W-1:0] o_year,
  output logic [7:0]        o_month,
  output logic [7:0]        o_day,
  output logic [7:0]        o_hour,
  output logic [7:0]        o_minute,
  output logic [7:0]        o_second,
  output logic [2:0]        o_week,
  output logic [4:0]        o_max_date,
  output logic [3:0]        o_hour12,
  output logic              o_pm,
  output logic              o_set_err,
  output logic              o_min_tick,
  output logic              o_hour_tick,
  output logic              o_day_tick,
  output logic              o_alarm_hit
);

  localparam logic [YEAR_W-1:0] C_YMIN  = YEAR_W'(YEAR_MIN);
  localparam logic [YEAR_W-1:0] C_YMAX  = YEAR_W'(YEAR_MAX);
  localparam logic [YEAR_W-1:0] C_RST_Y = YEAR_W'(RST_YEAR);
  localparam logic [7:0]        C_RST_M = 8'(RST_MONTH);
  localparam logic [7:0]        C_RST_D = 8'(RST_DAY);
  localparam logic [7:0]        C_RST_H = 8'(RST_HOUR);
  localparam logic [2:0]        C_RST_W = 3'(RST_WEEK);

  function automatic logic [4:0] days_in_month(input logic [YEAR_W-1:0] y,
                                                input logic [7:0] m);
    int  yi;
    logic leap;
    yi   = int'(y);
    leap = ((yi % 4 == 0) && (yi % 100 != 0)) || (yi % 400 == 0);
    case (m)
      8'd1, 8'd3, 8'd5, 8'd7, 8'd8, 8'd10, 8'd12: days_in_month = 5'd31;
      8'd4, 8'd6, 8'd9, 8'd11:                    days_in_month = 5'd30;
      8'd2:                                       days_in_month = leap ? 5'd29 : 5'd28;
      default:                                    days_in_month = 5'd0;
    endcase
  endfunction

  logic [YEAR_W-1:0] r_year;
  logic [7:0]        r_month, r_day, r_hour, r_min, r_sec;
  logic [2:0]        r_week;
  logic              r_set_err, r_min_tick, r_hour_tick, r_day_tick, r_alarm_hit;

  logic [YEAR_W-1:0] w_n_year;
  logic [7:0]        w_n_month, w_n_day, w_n_hour, w_n_min, w_n_sec;
  logic [2:0]        w_n_week;
  logic              w_n_set_err, w_n_min_tick, w_n_hour_tick, w_n_day_tick, w_n_alarm;

  logic [YEAR_W-1:0] w_set_year;
  logic [7:0]        w_set_month, w_set_day, w_set_hour, w_set_min, w_set_sec;
  logic [4:0]        w_set_dim;
  logic              w_set_ok;
  logic [4:0]        w_max_date;
  logic [7:0]        w_hour_m12;

  assign w_set_year  = i_bin_time[YEAR_W+39:40];
  assign w_set_month = i_bin_time[39:32];
  assign w_set_day   = i_bin_time[31:24];
  assign w_set_hour  = i_bin_time[23:16];
  assign w_set_min   = i_bin_time[15:8];
  assign w_set_sec   = i_bin_time[7:0];

  // Day limit is taken from the requested year/month, not the current one.
  assign w_set_dim = days_in_month(w_set_year, w_set_month);
  assign w_set_ok  = (w_set_year >= C_YMIN) && (w_set_year <= C_YMAX) &&
                     (w_set_month >= 8'd1) && (w_set_month <= 8'd12) &&
                     (w_set_day >= 8'd1) && (w_set_day <= {3'b000, w_set_dim}) &&
                     (w_set_hour < 8'd24) && (w_set_min < 8'd60) &&
                     (w_set_sec < 8'd60) && (i_set_week < 3'd7);

  assign w_max_date = days_in_month(r_year, r_month);

  always_comb begin
    w_n_year      = r_year;
    w_n_month     = r_month;
    w_n_day       = r_day;
    w_n_hour      = r_hour;
    w_n_min       = r_min;
    w_n_sec       = r_sec;
    w_n_week      = r_week;
    w_n_set_err   = 1'b0;
    w_n_min_tick  = 1'b0;
    w_n_hour_tick = 1'b0;
    w_n_day_tick  = 1'b0;
    w_n_alarm     = 1'b0;
    if (i_set_time) begin
      if (w_set_ok) begin
        w_n_year  = w_set_year;
        w_n_month = w_set_month;
        w_n_day   = w_set_day;
        w_n_hour  = w_set_hour;
        w_n_min   = w_set_min;
        w_n_sec   = w_set_sec;
        w_n_week  = i_set_week;
      end else begin
        w_n_set_err = 1'b1;
      end
    end else if (i_clk1sec) begin
      if (r_sec == 8'd59) begin
        w_n_sec      = 8'd0;
        w_n_min_tick = 1'b1;
        if (r_min == 8'd59) begin
          w_n_min       = 8'd0;
          w_n_hour_tick = 1'b1;
          if (r_hour == 8'd23) begin
            w_n_hour     = 8'd0;
            w_n_day_tick = 1'b1;
            w_n_week     = (r_week >= 3'd6) ? 3'd0 : r_week + 3'd1;
            if (r_day >= {3'b000, w_max_date}) begin
              w_n_day = 8'd1;
              if (r_month >= 8'd12) begin
                w_n_month = 8'd1;
                w_n_year  = (r_year >= C_YMAX) ? C_YMIN : r_year + 1'b1;
              end else begin
                w_n_month = r_month + 8'd1;
              end
            end else begin
              w_n_day = r_day + 8'd1;
            end
          end else begin
            w_n_hour = r_hour + 8'd1;
          end
        end else begin
          w_n_min = r_min + 8'd1;
        end
      end else begin
        w_n_sec = r_sec + 8'd1;
      end
      // Next-state hour/minute are always in range, so bad alarm settings never match.
      w_n_alarm = i_alarm_en && (w_n_hour == i_alarm_hour) &&
                  (w_n_min == i_alarm_min) && (w_n_sec == 8'd0);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_year      <= C_RST_Y;
      r_month     <= C_RST_M;
      r_day       <= C_RST_D;
      r_hour      <= C_RST_H;
      r_min       <= 8'd0;
      r_sec       <= 8'd0;
      r_week      <= C_RST_W;
      r_set_err   <= 1'b0;
      r_min_tick  <= 1'b0;
      r_hour_tick <= 1'b0;
      r_day_tick  <= 1'b0;
      r_alarm_hit <= 1'b0;
    end else begin
      r_year      <= w_n_year;
      r_month     <= w_n_month;
      r_day       <= w_n_day;
      r_hour      <= w_n_hour;
      r_min       <= w_n_min;
      r_sec       <= w_n_sec;
      r_week      <= w_n_week;
      r_set_err   <= w_n_set_err;
      r_min_tick  <= w_n_min_tick;
      r_hour_tick <= w_n_hour_tick;
      r_day_tick  <= w_n_day_tick;
      r_alarm_hit <= w_n_alarm;
    end
  end

  assign w_hour_m12 = r_hour - 8'd12;

  always_comb begin
    o_hour12 = r_hour[3:0];
    if (r_hour == 8'd0)      o_hour12 = 4'd12;
    else if (r_hour > 8'd12) o_hour12 = w_hour_m12[3:0];
  end

  assign o_pm        = (r_hour >= 8'd12);
  assign o_year      = r_year;
  assign o_month     = r_month;
  assign o_day       = r_day;
  assign o_hour      = r_hour;
  assign o_minute    = r_min;
  assign o_second    = r_sec;
  assign o_week      = r_week;
  assign o_max_date  = w_max_date;
  assign o_set_err   = r_set_err;
  assign o_min_tick  = r_min_tick;
  assign o_hour_tick = r_hour_tick;
  assign o_day_tick  = r_day_tick;
  assign o_alarm_hit = r_alarm_hit;

endmodule
